// File: rtl/mem_responder.sv
// mem_responder: single-outstanding word memory responder with a valid/ready
// request channel, a programmable number of wait states, and a registered
// response that holds until the initiator takes it.
module mem_responder #(
    parameter logic [31:0] BASE        = 32'h1001_0000,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAccess,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem_q [DEPTH];

    logic [31:0] word_idx;
    logic [AW-1:0] mem_idx;
    logic        access_err;
    logic        mem_we;

    // Address decode of the captured request
    always_comb begin
        word_idx   = (addr_q - BASE) >> 2;
        mem_idx    = word_idx[AW-1:0];
        access_err = (addr_q[1:0] != 2'b00) || (addr_q < BASE) || (word_idx >= DEPTH);
    end

    // Next-state, capture and response logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES > 0) ? StWait : StAccess;
                end
            end
            StWait: begin
                // Counter saturates at zero; zero is also treated as done so
                // the FSM can never stall here.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
                if (cnt_q <= 4'd1) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                rsp_err_d   = access_err;
                rsp_rdata_d = (access_err || we_q) ? 32'h0 : mem_q[mem_idx];
                mem_we      = we_q && !access_err;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and response registers, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage array with byte-enabled writes; deliberately not reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && be_q[b]) begin
                mem_q[mem_idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    // Handshake outputs decoded from state only
    always_comb begin
        req_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
        rsp_rdata = rsp_rdata_q;
        rsp_err   = rsp_err_q;
    end

endmodule
